// File: rtl/bin_to_excess3_seq_pkg.sv
// Shared types and constants for the binary-to-excess-3 encoder.
// max_digits() gives the decimal digits needed to hold 2^bin_w, which sizes the BCD register.
package xs3_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    localparam logic [3:0] XS3_BIAS  = 4'd3;
    localparam logic [3:0] DD_THRESH = 4'd5;

    // 2^bin_w itself is never a power of ten, so counting its digits gives the
    // smallest D with 10^D > 2^bin_w.
    function automatic int max_digits(input int bin_w);
        longint unsigned val;
        int digits;
        val    = 64'd1 << bin_w;
        digits = 1;
        while (val >= 64'd10) begin
            val    = val / 64'd10;
            digits = digits + 1;
        end
        return digits;
    endfunction

endpackage

// File: rtl/bin_to_excess3_seq_if.sv
// Handshake bundle for the excess-3 encoder: input word channel and result channel.
interface bin_to_excess3_seq_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [BIN_W-1:0]      bin_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   xs3_out;

    modport master (
        output in_valid, bin_in, out_ready,
        input  in_ready, out_valid, xs3_out
    );

    modport slave (
        input  in_valid, bin_in, out_ready,
        output in_ready, out_valid, xs3_out
    );
endinterface

// File: rtl/bin_to_excess3_seq_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
module bcd_digit_adj
    import xs3_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= DD_THRESH) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/bin_to_excess3_seq.sv
// Iterative binary-to-excess-3 encoder: one double-dabble step per cycle, then a +3 bias per digit.
module bin_to_excess3_seq
    import xs3_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bin_to_excess3_seq_if.slave  bus
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;

    if (BIN_W < 1 || DIGITS < max_digits(BIN_W)) begin : g_param_err
        $error("bin_to_excess3_seq: need BIN_W >= 1 and 10^DIGITS > 2^BIN_W");
    end

    state_e             state_q;
    logic [BIN_W-1:0]   bin_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [BCD_W-1:0]   xs3_q;
    logic               in_ready_q;
    logic               out_valid_q;

    logic [BCD_W-1:0]   adj_d;
    logic [BCD_W-1:0]   bcd_shift_d;
    logic [BIN_W-1:0]   bin_shift_d;
    logic [BCD_W-1:0]   xs3_d;

    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (bcd_q[4*k +: 4]),
            .digit_o (adj_d[4*k +: 4])
        );
    end

    // The top bit of the adjusted BCD falls off the end; it can never be set for legal digits.
    assign {bcd_shift_d, bin_shift_d} = {adj_d, bin_q} << 1;

    always_comb begin
        xs3_d = '0;
        for (int k = 0; k < DIGITS; k++) begin
            xs3_d[4*k +: 4] = bcd_shift_d[4*k +: 4] + XS3_BIAS;
        end
    end

    // in_ready/out_valid are registered alongside the state so no input reaches an output combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            xs3_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        bin_q      <= bus.bin_in;
                        bcd_q      <= '0;
                        cnt_q      <= CNT_W'(BIN_W);
                        in_ready_q <= 1'b0;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    bin_q <= bin_shift_d;
                    bcd_q <= bcd_shift_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        xs3_q       <= xs3_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.xs3_out   = xs3_q;

endmodule

// File: tb/tb_bin_to_excess3_seq.sv
// Self-checking bench for bin_to_excess3_seq: directed cases, backpressure, mid-conversion reset
// and a randomized-gap sweep of every input value against a decimal-digit reference model.
module tb_bin_to_excess3_seq;

    localparam int BIN_W  = 8;
    localparam int DIGITS = 3;

    logic clk;
    logic rst_n;
    int   checkCount;
    int   passCount;

    bin_to_excess3_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    bin_to_excess3_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: split into decimal digits arithmetically and bias each by 3.
    function automatic logic [11:0] xs3Model(input int value);
        int rem;
        logic [11:0] r;
        rem = value;
        r   = '0;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'((rem % 10) + 3);
            rem = rem / 10;
        end
        return r;
    endfunction

    task automatic acceptWord(input logic [7:0] value);
        int guard;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.bin_in   = value;
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
    endtask

    // Returns the cycle (counted from the accept edge) in which out_valid is first seen, or -1.
    task automatic waitResult(output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.in_valid = 1'b0;
                bus.bin_in   = 8'($urandom);
            end
            if (bus.out_valid === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic releaseResult();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.bin_in    = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkCount++;
        if (bus.in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready got=%b expected=0", bus.in_ready);
        else passCount++;
        checkCount++;
        if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got=%b expected=0", bus.out_valid);
        else passCount++;
        checkCount++;
        if (bus.xs3_out !== 12'h000) $display("[TB] FAIL reset_xs3_out got=%h expected=000", bus.xs3_out);
        else passCount++;
        rst_n = 1'b1;
        @(negedge clk);
        checkCount++;
        if (bus.in_ready !== 1'b1) $display("[TB] FAIL post_reset_in_ready got=%b expected=1", bus.in_ready);
        else passCount++;
    endtask

    task automatic test_zero();
        int lat;
        acceptWord(8'd0);
        waitResult(lat);
        checkCount++;
        if (lat !== 9) $display("[TB] FAIL zero_latency got=%0d expected=9", lat);
        else passCount++;
        checkCount++;
        if (bus.xs3_out !== 12'h333) $display("[TB] FAIL zero_value got=%h expected=333", bus.xs3_out);
        else passCount++;
        releaseResult();
    endtask

    task automatic test_directed();
        logic [7:0]  vals [3];
        logic [11:0] exps [3];
        int lat;
        vals = '{8'd255, 8'd100, 8'd9};
        exps = '{12'h588, 12'h433, 12'h33C};
        for (int i = 0; i < 3; i++) begin
            acceptWord(vals[i]);
            waitResult(lat);
            checkCount++;
            if (lat !== 9) $display("[TB] FAIL directed_latency in=%0d got=%0d expected=9", vals[i], lat);
            else passCount++;
            checkCount++;
            if (bus.xs3_out !== exps[i])
                $display("[TB] FAIL directed_value in=%0d got=%h expected=%h", vals[i], bus.xs3_out, exps[i]);
            else passCount++;
            releaseResult();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int strayCount;
        logic [11:0] expVal;
        expVal = xs3Model(123);
        acceptWord(8'd123);
        waitResult(lat);
        checkCount++;
        if (lat !== 9) $display("[TB] FAIL bp_latency got=%0d expected=9", lat);
        else passCount++;
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = (c == 2);
            bus.bin_in   = 8'd7;
            @(negedge clk);
            checkCount++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.xs3_out !== expVal)
                $display("[TB] FAIL bp_hold cycle=%0d got=v%b r%b %h expected=v1 r0 %h",
                         c, bus.out_valid, bus.in_ready, bus.xs3_out, expVal);
            else passCount++;
        end
        bus.in_valid = 1'b0;
        releaseResult();
        checkCount++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("[TB] FAIL bp_release got=v%b r%b expected=v0 r1", bus.out_valid, bus.in_ready);
        else passCount++;
        strayCount = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) strayCount++;
        end
        checkCount++;
        if (strayCount !== 0) $display("[TB] FAIL bp_stray_result got=%0d expected=0", strayCount);
        else passCount++;
    endtask

    task automatic test_reset_mid();
        int lat;
        int strayCount;
        acceptWord(8'd200);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkCount++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.xs3_out !== 12'h000)
            $display("[TB] FAIL mid_reset_async got=r%b v%b %h expected=r0 v0 000",
                     bus.in_ready, bus.out_valid, bus.xs3_out);
        else passCount++;
        @(negedge clk);
        rst_n = 1'b1;
        strayCount = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) strayCount++;
        end
        checkCount++;
        if (strayCount !== 0) $display("[TB] FAIL mid_reset_stray got=%0d expected=0", strayCount);
        else passCount++;
        acceptWord(8'd37);
        waitResult(lat);
        checkCount++;
        if (lat !== 9) $display("[TB] FAIL after_reset_latency got=%0d expected=9", lat);
        else passCount++;
        checkCount++;
        if (bus.xs3_out !== 12'h36A) $display("[TB] FAIL after_reset_value got=%h expected=36a", bus.xs3_out);
        else passCount++;
        releaseResult();
    endtask

    task automatic test_sweep();
        logic [11:0] expQ [$];
        logic [11:0] expVal;
        logic [3:0]  dig;
        int nextVal;
        int accepts;
        int results;
        bit rangeOk;
        nextVal = 0;
        accepts = 0;
        results = 0;
        for (int cyc = 0; cyc < 20000 && results < 256; cyc++) begin
            @(negedge clk);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                results++;
                checkCount++;
                if (expQ.size() == 0) begin
                    $display("[TB] FAIL sweep_order got=%h expected=<none>", bus.xs3_out);
                end else begin
                    expVal = expQ.pop_front();
                    if (bus.xs3_out !== expVal)
                        $display("[TB] FAIL sweep_value idx=%0d got=%h expected=%h", results - 1, bus.xs3_out, expVal);
                    else passCount++;
                end
                rangeOk = 1'b1;
                for (int k = 0; k < DIGITS; k++) begin
                    dig = bus.xs3_out[4*k +: 4];
                    if (dig < 4'd3 || dig > 4'd12) rangeOk = 1'b0;
                end
                checkCount++;
                if (!rangeOk) $display("[TB] FAIL sweep_digit_range got=%h expected=digits 3..12", bus.xs3_out);
                else passCount++;
            end
            if (nextVal < 256) begin
                bus.in_valid = ($urandom_range(0, 2) != 0);
                bus.bin_in   = bus.in_valid ? 8'(nextVal) : 8'($urandom);
                if (bus.in_valid && bus.in_ready === 1'b1) begin
                    expQ.push_back(xs3Model(nextVal));
                    nextVal++;
                    accepts++;
                end
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checkCount++;
        if (accepts !== 256) $display("[TB] FAIL sweep_accepts got=%0d expected=256", accepts);
        else passCount++;
        checkCount++;
        if (results !== accepts) $display("[TB] FAIL sweep_result_count got=%0d expected=%0d", results, accepts);
        else passCount++;
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        test_reset();
        test_zero();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
